// File: rtl/cellrv32_cpu_cp_arbiter.sv
// ---------------------------------------------------------------------------
// cellrv32_cpu_cp_arbiter
// Initiator-side controller for the CPU co-processor interface. Issues a
// one-cycle start to the selected co-processor, waits for its valid flag,
// captures its result slice and returns it with a one-cycle done pulse.
// A trap aborts an operation in flight. A watchdog turns a hung unit, or an
// out-of-range selection, into a one-cycle timeout pulse.
//
// States:
//   state     | meaning
//   ----------+----------------------------------------------
//   S_IDLE    | waiting for a request
//   S_BUSY    | start issued, waiting for the selected valid
//   S_CAPTURE | result slice of the selected unit is sampled
//   S_DONE    | done asserted for one cycle
//
// Ports:
//   clk_i       clock, rising edge
//   rstn_i      asynchronous active-low reset
//   req_i       one-cycle operation request
//   sel_i       target co-processor index, sampled with req_i
//   trap_i      CPU trap, aborts an operation in BUSY/CAPTURE
//   cp_start_o  one-hot start pulse (combinational, acceptance cycle)
//   cp_valid_i  per-unit valid flags
//   cp_res_i    flattened results, slice k = [k*XLEN +: XLEN]
//   busy_o      operation in flight
//   done_o      one-cycle pulse, res_o valid
//   res_o       captured result, held until the next capture
//   tmo_o       one-cycle pulse on watchdog expiry or invalid selection
// ---------------------------------------------------------------------------
module cellrv32_cpu_cp_arbiter #(
  parameter int XLEN       = 32,
  parameter int NUM_CP     = 4,
  parameter int TMO_CYCLES = 128
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     req_i,
  input  logic [$clog2(NUM_CP)-1:0] sel_i,
  input  logic                     trap_i,
  output logic [NUM_CP-1:0]        cp_start_o,
  input  logic [NUM_CP-1:0]        cp_valid_i,
  input  logic [NUM_CP*XLEN-1:0]   cp_res_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [XLEN-1:0]          res_o,
  output logic                     tmo_o
);

  localparam int SEL_W = $clog2(NUM_CP);
  localparam int CNT_W = $clog2(TMO_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TMO_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY    = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [SEL_W-1:0] sel_q;
  logic [XLEN-1:0]  res_q;
  logic             tmo_q;

  logic             sel_ok;
  logic             accept;
  logic             valid_in;
  logic             valid_sel;
  logic [XLEN-1:0]  res_sel;

  // Muxes are built with explicit compares so an out-of-range sel_i (possible
  // when NUM_CP is not a power of two) never indexes past the vectors.
  always_comb begin
    sel_ok     = (32'(sel_i) < 32'(NUM_CP));
    accept     = (state == S_IDLE) && req_i && !trap_i && sel_ok;
    valid_in   = 1'b0;
    valid_sel  = 1'b0;
    res_sel    = '0;
    cp_start_o = '0;
    for (int k = 0; k < NUM_CP; k++) begin
      if (sel_i == SEL_W'(k)) begin
        valid_in      = cp_valid_i[k];
        cp_start_o[k] = accept;
      end
      if (sel_q == SEL_W'(k)) begin
        valid_sel = cp_valid_i[k];
        res_sel   = cp_res_i[k*XLEN +: XLEN];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state <= S_IDLE;
      cnt   <= '0;
      sel_q <= '0;
      res_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      tmo_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            sel_q <= sel_i;
            cnt   <= '0;
            // single-cycle units already report valid in the request cycle
            state <= valid_in ? S_CAPTURE : S_BUSY;
          end else if (req_i && !trap_i) begin
            // only reachable with an out-of-range selection
            tmo_q <= 1'b1;
          end
        end
        S_BUSY: begin
          if (trap_i) begin
            state <= S_IDLE;
          end else if (valid_sel) begin
            state <= S_CAPTURE;
          end else if (cnt == CNT_LAST) begin
            tmo_q <= 1'b1;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_CAPTURE: begin
          if (trap_i) begin
            state <= S_IDLE;
          end else begin
            res_q <= res_sel;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          // result already committed, trap has no effect here
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy_o = (state != S_IDLE);
  assign done_o = (state == S_DONE);
  assign res_o  = res_q;
  assign tmo_o  = tmo_q;

endmodule

// File: tb/tb_cellrv32_cpu_cp_arbiter.sv
module tb_cellrv32_cpu_cp_arbiter;

  logic         clk_i = 1'b0;
  logic         rstn_i;
  logic         req_i, trap_i;
  logic [1:0]   sel_i;
  logic [3:0]   cp_start_o, cp_valid_i;
  logic [127:0] cp_res_i;
  logic         busy_o, done_o, tmo_o;
  logic [31:0]  res_o;

  logic         req3;
  logic [1:0]   sel3;
  logic [2:0]   start3, valid3;
  logic [95:0]  res_in3;
  logic         busy3, done3, tmo3;
  logic [31:0]  res3;

  int checks = 0;
  int passed = 0;

  always #5 clk_i = ~clk_i;

  cellrv32_cpu_cp_arbiter #(.XLEN(32), .NUM_CP(4), .TMO_CYCLES(128)) u_dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .req_i(req_i), .sel_i(sel_i), .trap_i(trap_i),
    .cp_start_o(cp_start_o), .cp_valid_i(cp_valid_i), .cp_res_i(cp_res_i),
    .busy_o(busy_o), .done_o(done_o), .res_o(res_o), .tmo_o(tmo_o));

  cellrv32_cpu_cp_arbiter #(.XLEN(32), .NUM_CP(3), .TMO_CYCLES(16)) u_dut3 (
    .clk_i(clk_i), .rstn_i(rstn_i), .req_i(req3), .sel_i(sel3), .trap_i(1'b0),
    .cp_start_o(start3), .cp_valid_i(valid3), .cp_res_i(res_in3),
    .busy_o(busy3), .done_o(done3), .res_o(res3), .tmo_o(tmo3));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // advance to the next cycle (negedge) and return all stimulus to idle
  task automatic tick();
    @(negedge clk_i);
    req_i = 1'b0; sel_i = 2'd0; trap_i = 1'b0; cp_valid_i = '0; cp_res_i = '0;
    req3 = 1'b0; sel3 = 2'd0; valid3 = '0; res_in3 = '0;
  endtask

  initial begin
    rstn_i = 1'b0;
    req_i = 1'b0; sel_i = 2'd0; trap_i = 1'b0; cp_valid_i = '0; cp_res_i = '0;
    req3 = 1'b0; sel3 = 2'd0; valid3 = '0; res_in3 = '0;
    tick(); tick();
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_tmo", tmo_o, 0);
    chk("rst_start", cp_start_o, 0);
    chk("rst_res", res_o, 0);
    rstn_i = 1'b1;

    // single-cycle unit, sel 1
    tick(); req_i = 1; sel_i = 2'd1; cp_valid_i = 4'b0010; #1;
    chk("sc_start", cp_start_o, 4'b0010);
    tick(); cp_res_i[32 +: 32] = 32'h8000_0001; #1;
    chk("sc_busy_t1", busy_o, 1);
    chk("sc_done_t1", done_o, 0);
    tick(); trap_i = 1; #1;
    chk("sc_done_t2", done_o, 1);
    chk("sc_res_t2", res_o, 32'h8000_0001);
    chk("sc_busy_t2", busy_o, 1);

    // back-to-back: multi-cycle unit 0 accepted right after done
    tick(); req_i = 1; sel_i = 2'd0; #1;
    chk("mc_done_clr", done_o, 0);
    chk("mc_busy_idle", busy_o, 0);
    chk("mc_start", cp_start_o, 4'b0001);
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (i == 5) cp_valid_i = 4'b0100;
      if (i == 10) begin req_i = 1; sel_i = 2'd1; end
      #1;
      chk("mc_nostart", cp_start_o, 0);
      chk("mc_busy", busy_o, 1);
      chk("mc_nodone", done_o, 0);
    end
    tick(); cp_valid_i = 4'b0001; #1;
    chk("mc_busy31", busy_o, 1);
    tick(); cp_res_i[0 +: 32] = 32'h0000_F000; #1;
    chk("mc_done32", done_o, 0);
    tick(); #1;
    chk("mc_done33", done_o, 1);
    chk("mc_res33", res_o, 32'h0000_F000);

    // trap abort in BUSY, then immediate new request
    tick(); req_i = 1; sel_i = 2'd2; #1;
    chk("tr_start", cp_start_o, 4'b0100);
    tick(); tick();
    tick(); trap_i = 1; #1;
    chk("tr_busy3", busy_o, 1);
    tick(); req_i = 1; sel_i = 2'd2; #1;
    chk("tr_busy4", busy_o, 0);
    chk("tr_done4", done_o, 0);
    chk("tr_tmo4", tmo_o, 0);
    chk("tr_res4", res_o, 32'h0000_F000);
    chk("tr_restart", cp_start_o, 4'b0100);
    tick(); cp_valid_i = 4'b0100; #1;
    tick(); cp_res_i[64 +: 32] = 32'h1234_5678; #1;
    tick(); #1;
    chk("tr_done7", done_o, 1);
    chk("tr_res7", res_o, 32'h1234_5678);

    // trap during CAPTURE leaves res unchanged
    tick(); req_i = 1; sel_i = 2'd2; cp_valid_i = 4'b0100; #1;
    tick(); trap_i = 1; cp_res_i[64 +: 32] = 32'hDEAD_BEEF; #1;
    tick(); #1;
    chk("tc_busy", busy_o, 0);
    chk("tc_done", done_o, 0);
    chk("tc_res", res_o, 32'h1234_5678);

    // watchdog on unit 3
    tick(); req_i = 1; sel_i = 2'd3; #1;
    chk("wd_start", cp_start_o, 4'b1000);
    for (int i = 1; i <= 128; i++) begin
      tick(); #1;
      if (tmo_o !== 1'b0) chk("wd_early_tmo", tmo_o, 0);
    end
    chk("wd_busy128", busy_o, 1);
    tick(); #1;
    chk("wd_tmo129", tmo_o, 1);
    chk("wd_busy129", busy_o, 0);
    chk("wd_done129", done_o, 0);
    tick(); #1;
    chk("wd_tmo130", tmo_o, 0);

    // watchdog with trap in the expiry cycle
    tick(); req_i = 1; sel_i = 2'd3; #1;
    for (int i = 1; i <= 127; i++) tick();
    tick(); trap_i = 1; #1;
    chk("wt_busy128", busy_o, 1);
    tick(); #1;
    chk("wt_tmo129", tmo_o, 0);
    chk("wt_busy129", busy_o, 0);

    // invalid select on a 3-unit instance
    tick(); req3 = 1; sel3 = 2'd3; #1;
    chk("inv_start", start3, 0);
    tick(); #1;
    chk("inv_tmo", tmo3, 1);
    chk("inv_busy", busy3, 0);
    tick(); #1;
    chk("inv_tmo_clr", tmo3, 0);

    // asynchronous reset mid-operation
    tick(); req_i = 1; sel_i = 2'd0; #1;
    tick(); #1;
    chk("ar_busy_pre", busy_o, 1);
    chk("ar_res_pre", res_o, 32'h1234_5678);
    #2 rstn_i = 1'b0; #1;
    chk("ar_busy", busy_o, 0);
    chk("ar_res", res_o, 0);
    chk("ar_done", done_o, 0);
    tick(); rstn_i = 1'b1; cp_valid_i = 4'b0001;
    tick(); #1;
    chk("ar_done_after", done_o, 0);
    chk("ar_tmo_after", tmo_o, 0);
    chk("ar_busy_after", busy_o, 0);
    tick(); #1;
    chk("ar_done_after2", done_o, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
